// File: rtl/obi_rr_arb.sv
// Round-robin OBI arbiter: NumMgr managers share one subordinate; an ID FIFO routes R beats back.
// Define OBI_RR_ARB_PRIO_EN to give manager 0 fixed priority over a round-robin group of 1..NumMgr-1.
package obi_pkg;
  typedef struct packed { bit UseRReady; } obi_cfg_t;
  localparam obi_cfg_t ObiDefaultConfig = '{UseRReady: 1'b0};
  typedef struct packed {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [3:0]  aid;
  } obi_a_chan_t;
  typedef struct packed {
    logic [31:0] rdata;
    logic [3:0]  rid;
    logic        err;
  } obi_r_chan_t;
  typedef struct packed { obi_a_chan_t a; logic req; logic rready; } obi_req_t;
  typedef struct packed { obi_r_chan_t r; logic gnt; logic rvalid; } obi_rsp_t;
endpackage

module obi_rr_arb #(
  parameter obi_pkg::obi_cfg_t ObiCfg      = obi_pkg::ObiDefaultConfig,
  parameter type               obi_req_t   = obi_pkg::obi_req_t,
  parameter type               obi_rsp_t   = obi_pkg::obi_rsp_t,
  parameter int unsigned       NumMgr      = 2,
  parameter int unsigned       NumMaxTrans = 2
) (
  input  logic     clk_i,
  input  logic     rst_i,
  input  logic     testmode_i,
  input  obi_req_t mgr_req_i [NumMgr],
  output obi_rsp_t mgr_rsp_o [NumMgr],
  output obi_req_t sbr_req_o,
  input  obi_rsp_t sbr_rsp_i
);
  localparam int unsigned IdxW = $clog2(NumMgr);
  localparam int unsigned PtrW = (NumMaxTrans > 1) ? $clog2(NumMaxTrans) : 1;
  localparam int unsigned CntW = $clog2(NumMaxTrans + 1);

  logic [IdxW-1:0] rr_ptr_q, rr_ptr_d, lock_idx_q, lock_idx_d, sel_idx, head_idx;
  logic            lock_q, lock_d, err_q, err_d;
  logic            sel_valid, fifo_full, fifo_empty, sbr_req_vld, hs, pop, rready_head;
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [IdxW-1:0] id_mem_q [NumMaxTrans];
  logic [NumMgr-1:0] req_vec;
  logic            unused_testmode;

  assign unused_testmode = testmode_i;

  for (genvar gi = 0; gi < NumMgr; gi++) begin : g_req
    assign req_vec[gi] = mgr_req_i[gi].req;
  end

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(NumMaxTrans - 1)) ? '0 : p + 1'b1;
  endfunction

  // A held lock overrides the search so a waiting manager keeps its A channel on the bus.
  always_comb begin
    int unsigned cand;
    int unsigned base;
    sel_valid = 1'b0;
    sel_idx   = '0;
    cand      = 0;
    base      = 0;
    if (lock_q) begin
      sel_valid = req_vec[lock_idx_q];
      sel_idx   = lock_idx_q;
    end else begin
`ifdef OBI_RR_ARB_PRIO_EN
      if (req_vec[0]) begin
        sel_valid = 1'b1;
      end else begin
        base = (rr_ptr_q == '0) ? 0 : 32'(rr_ptr_q) - 1;
        for (int unsigned k = 0; k < NumMgr - 1; k++) begin
          cand = 1 + ((base + k) % (NumMgr - 1));
          if (!sel_valid && req_vec[IdxW'(cand)]) begin
            sel_valid = 1'b1;
            sel_idx   = IdxW'(cand);
          end
        end
      end
`else
      for (int unsigned k = 0; k < NumMgr; k++) begin
        cand = (32'(rr_ptr_q) + k) % NumMgr;
        if (!sel_valid && req_vec[IdxW'(cand)]) begin
          sel_valid = 1'b1;
          sel_idx   = IdxW'(cand);
        end
      end
`endif
    end
  end

  assign fifo_empty  = (cnt_q == '0);
  assign fifo_full   = (cnt_q == CntW'(NumMaxTrans));
  assign sbr_req_vld = sel_valid && !fifo_full && !rst_i;
  assign hs          = sbr_req_vld && sbr_rsp_i.gnt;
  assign head_idx    = id_mem_q[rd_ptr_q];
  assign rready_head = ObiCfg.UseRReady ? mgr_req_i[head_idx].rready : 1'b1;
  assign pop         = !fifo_empty && !rst_i && sbr_rsp_i.rvalid && rready_head;

  always_comb begin
    sbr_req_o        = mgr_req_i[sel_idx];
    sbr_req_o.req    = sbr_req_vld;
    // With nothing outstanding a stray beat is accepted and dropped rather than stalled.
    sbr_req_o.rready = fifo_empty ? 1'b1 : rready_head;
  end

  always_comb begin
    for (int unsigned k = 0; k < NumMgr; k++) begin
      mgr_rsp_o[k]        = sbr_rsp_i;
      mgr_rsp_o[k].gnt    = hs && (sel_idx == IdxW'(k));
      mgr_rsp_o[k].rvalid = !fifo_empty && !rst_i && sbr_rsp_i.rvalid && (head_idx == IdxW'(k));
    end
  end

  always_comb begin
    lock_d     = lock_q;
    lock_idx_d = lock_idx_q;
    rr_ptr_d   = rr_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    cnt_d      = cnt_q;
    err_d      = err_q | (sbr_rsp_i.rvalid && fifo_empty);
    if (hs) begin
      lock_d   = 1'b0;
      rr_ptr_d = (sel_idx == IdxW'(NumMgr - 1)) ? '0 : sel_idx + 1'b1;
      wr_ptr_d = ptr_inc(wr_ptr_q);
    end else if (sel_valid) begin
      lock_d     = 1'b1;
      lock_idx_d = sel_idx;
    end
    if (pop) rd_ptr_d = ptr_inc(rd_ptr_q);
    case ({hs, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rr_ptr_q   <= '0;
      lock_q     <= 1'b0;
      lock_idx_q <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cnt_q      <= '0;
      err_q      <= 1'b0;
    end else begin
      rr_ptr_q   <= rr_ptr_d;
      lock_q     <= lock_d;
      lock_idx_q <= lock_idx_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      cnt_q      <= cnt_d;
      err_q      <= err_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (hs) id_mem_q[wr_ptr_q] <= sel_idx;
  end
endmodule

// File: tb/tb_obi_rr_arb.sv
// Bench for obi_rr_arb (3 managers, 2 outstanding, rready enabled): directed scenarios then random traffic
// checked every cycle against a queue-based model of the arbitration and response routing rules.
module tb_obi_rr_arb;
  import obi_pkg::*;
  localparam int N = 3;
  localparam int M = 2;
  localparam obi_cfg_t Cfg = '{UseRReady: 1'b1};

  logic     clk = 1'b0;
  logic     rst;
  logic     testmode;
  obi_req_t mgr_req [N];
  obi_rsp_t mgr_rsp [N];
  obi_req_t sbr_req;
  obi_rsp_t sbr_rsp;

  always #5 clk = ~clk;

  obi_rr_arb #(
    .ObiCfg(Cfg), .obi_req_t(obi_req_t), .obi_rsp_t(obi_rsp_t), .NumMgr(N), .NumMaxTrans(M)
  ) dut (
    .clk_i(clk), .rst_i(rst), .testmode_i(testmode),
    .mgr_req_i(mgr_req), .mgr_rsp_o(mgr_rsp), .sbr_req_o(sbr_req), .sbr_rsp_i(sbr_rsp)
  );

  int total = 0;
  int bad   = 0;
  int q[$];
  int rr = 0;
  int lk = -1;
  bit err_m = 1'b0;

  logic [N-1:0] gnt_seen = '0, rv_seen = '0;
  logic         req_seen = 1'b0, rdy_seen = 1'b0, err_seen = 1'b0;
  logic [31:0]  addr_seen = '0;
  logic [31:0]  rdata_seen [N];

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total++;
    assert (act === exp) else begin
      bad++;
      $error("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Inputs are set at the negedge; outputs are checked 1ns later and the model steps at the posedge.
  task automatic tick();
    int sel, head;
    bit exp_req, pop;
    logic [N-1:0] exp_gnt, exp_rv;
    #1;
    sel = -1;
    if (!rst) begin
      if (lk >= 0) sel = lk;
      else for (int k = 0; k < N; k++) if (sel < 0 && mgr_req[(rr + k) % N].req) sel = (rr + k) % N;
    end
    head    = (!rst && q.size() > 0) ? q[0] : -1;
    exp_req = (sel >= 0) && (q.size() < M);
    exp_gnt = '0;
    exp_rv  = '0;
    if (exp_req && sbr_rsp.gnt) exp_gnt[sel] = 1'b1;
    if (head >= 0 && sbr_rsp.rvalid) exp_rv[head] = 1'b1;
    for (int i = 0; i < N; i++) begin
      gnt_seen[i]   = mgr_rsp[i].gnt;
      rv_seen[i]    = mgr_rsp[i].rvalid;
      rdata_seen[i] = mgr_rsp[i].r.rdata;
    end
    req_seen  = sbr_req.req;
    rdy_seen  = sbr_req.rready;
    addr_seen = sbr_req.a.addr;
    err_seen  = dut.err_q;
    check("sbr_req", 32'(req_seen), 32'(exp_req));
    check("mgr_gnt", 32'(gnt_seen), 32'(exp_gnt));
    check("mgr_rvalid", 32'(rv_seen), 32'(exp_rv));
    check("err_q", 32'(err_seen), rst ? 32'd0 : 32'(err_m));
    if (sel >= 0) check("sbr_addr", addr_seen, mgr_req[sel].a.addr);
    if (head >= 0) begin
      check("sbr_rready", 32'(rdy_seen), 32'(mgr_req[head].rready));
      check("rdata", rdata_seen[head], sbr_rsp.r.rdata);
    end
    if (exp_req && sbr_rsp.gnt) $display("grant mgr=%0d addr=%08h", sel, mgr_req[sel].a.addr);
    if (head >= 0 && sbr_rsp.rvalid && mgr_req[head].rready)
      $display("resp  mgr=%0d rdata=%08h", head, sbr_rsp.r.rdata);
    @(posedge clk);
    if (rst) begin
      q.delete();
      rr = 0;
      lk = -1;
      err_m = 1'b0;
    end else begin
      pop = (head >= 0) && sbr_rsp.rvalid && mgr_req[head].rready;
      if (sbr_rsp.rvalid && head < 0) err_m = 1'b1;
      if (pop) void'(q.pop_front());
      if (exp_req && sbr_rsp.gnt) begin
        q.push_back(sel);
        rr = (sel + 1) % N;
        lk = -1;
      end else if (sel >= 0) begin
        lk = sel;
      end
    end
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    for (int i = 0; i < N; i++) mgr_req[i] = '0;
    sbr_rsp = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clear_inputs();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    int order [6] = '{0, 1, 2, 0, 1, 2};
    rst = 1'b1;
    testmode = 1'b0;
    clear_inputs();
    @(negedge clk);
    // Reset must mask active inputs.
    for (int i = 0; i < N; i++) begin
      mgr_req[i].req = 1'b1;
      mgr_req[i].rready = 1'b1;
    end
    sbr_rsp.gnt = 1'b1;
    sbr_rsp.rvalid = 1'b1;
    tick();
    tick();
    check("rst_gnt", 32'(gnt_seen), 32'd0);
    do_reset();

    // Continuous requests from all managers rotate 0,1,2,0,1,2.
    for (int i = 0; i < N; i++) begin
      mgr_req[i].req = 1'b1;
      mgr_req[i].rready = 1'b1;
      mgr_req[i].a.addr = 32'h100 * (i + 1);
    end
    sbr_rsp.gnt = 1'b1;
    for (int k = 0; k < 6; k++) begin
      sbr_rsp.rvalid = (k > 0);
      sbr_rsp.r.rdata = 32'(k);
      tick();
      check("rr_order", 32'(gnt_seen), 32'(1 << order[k]));
    end

    // Ungranted mgr1 keeps the bus while mgr0 joins.
    do_reset();
    mgr_req[1].req = 1'b1;
    mgr_req[1].a.addr = 32'h111;
    tick();
    check("lock_addr1", addr_seen, 32'h111);
    mgr_req[0].req = 1'b1;
    mgr_req[0].a.addr = 32'h222;
    tick();
    check("lock_addr2", addr_seen, 32'h111);
    tick();
    check("lock_addr3", addr_seen, 32'h111);
    sbr_rsp.gnt = 1'b1;
    tick();
    check("lock_gnt", 32'(gnt_seen), 32'b010);
    mgr_req[1].req = 1'b0;
    tick();
    check("after_lock_gnt", 32'(gnt_seen), 32'b001);

    // Full ID FIFO blocks requests, even in the popping cycle.
    do_reset();
    for (int i = 0; i < N; i++) begin
      mgr_req[i].req = 1'b1;
      mgr_req[i].rready = 1'b1;
    end
    sbr_rsp.gnt = 1'b1;
    tick();
    tick();
    tick();
    check("full_req", 32'(req_seen), 32'd0);
    check("full_gnt", 32'(gnt_seen), 32'd0);
    tick();
    sbr_rsp.rvalid = 1'b1;
    sbr_rsp.r.rdata = 32'h55;
    tick();
    check("full_pop_req", 32'(req_seen), 32'd0);
    sbr_rsp.rvalid = 1'b0;
    tick();
    check("refill_gnt", 32'(gnt_seen), 32'b100);

    // Responses follow grant order: mgr2 then mgr0.
    do_reset();
    for (int i = 0; i < N; i++) mgr_req[i].rready = 1'b1;
    mgr_req[2].req = 1'b1;
    sbr_rsp.gnt = 1'b1;
    tick();
    mgr_req[2].req = 1'b0;
    mgr_req[0].req = 1'b1;
    tick();
    mgr_req[0].req = 1'b0;
    sbr_rsp.rvalid = 1'b1;
    sbr_rsp.r.rdata = 32'hA;
    tick();
    check("route_a_vld", 32'(rv_seen), 32'b100);
    check("route_a_data", rdata_seen[2], 32'hA);
    sbr_rsp.r.rdata = 32'hB;
    tick();
    check("route_b_vld", 32'(rv_seen), 32'b001);
    check("route_b_data", rdata_seen[0], 32'hB);
    sbr_rsp.rvalid = 1'b0;
    tick();
    check("route_idle", 32'(rv_seen), 32'd0);

    // Head manager stalls R with rready low for two cycles.
    do_reset();
    mgr_req[1].req = 1'b1;
    sbr_rsp.gnt = 1'b1;
    tick();
    mgr_req[1].req = 1'b0;
    sbr_rsp.rvalid = 1'b1;
    sbr_rsp.r.rdata = 32'h77;
    tick();
    check("stall_rdy1", 32'(rdy_seen), 32'd0);
    tick();
    check("stall_rdy2", 32'(rdy_seen), 32'd0);
    check("stall_vld", 32'(rv_seen), 32'b010);
    mgr_req[1].rready = 1'b1;
    tick();
    check("stall_rdy3", 32'(rdy_seen), 32'd1);
    sbr_rsp.rvalid = 1'b0;
    tick();
    check("stall_done", 32'(rv_seen), 32'd0);

    // Reset discards outstanding IDs; a late beat is dropped and flagged.
    do_reset();
    mgr_req[0].req = 1'b1;
    sbr_rsp.gnt = 1'b1;
    tick();
    mgr_req[0].req = 1'b0;
    mgr_req[1].req = 1'b1;
    tick();
    mgr_req[1].req = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < N; i++) mgr_req[i].rready = 1'b1;
    sbr_rsp.rvalid = 1'b1;
    tick();
    check("drop_vld", 32'(rv_seen), 32'd0);
    sbr_rsp.rvalid = 1'b0;
    tick();
    check("drop_err", 32'(err_seen), 32'd1);

    // Random traffic; managers hold req and A stable until granted.
    do_reset();
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!(mgr_req[i].req && !gnt_seen[i])) begin
          mgr_req[i].req = ($urandom_range(0, 2) != 0);
          mgr_req[i].a.addr = $urandom;
          mgr_req[i].a.wdata = $urandom;
        end
        mgr_req[i].rready = ($urandom_range(0, 3) != 0);
      end
      sbr_rsp.gnt = ($urandom_range(0, 1) == 1);
      sbr_rsp.rvalid = (q.size() > 0) && ($urandom_range(0, 1) == 1);
      sbr_rsp.r.rdata = $urandom;
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
